// File: rtl/qos_demux_if.sv
// Word-stream bundle between the upstream source, qos_demux and the four class FIFOs.
// The slave modport is the demux side; the master modport is the source/sink side.
interface qos_demux_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic                  WRITE;
    logic [3:0]            almost_Full;
    logic [3:0]            Full;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic [3:0]            push;
    logic                  ready;
    logic                  pausa;

    modport slave (
        input  DATA_IN, WRITE, almost_Full, Full,
        output DATA_OUT, push, ready, pausa
    );

    modport master (
        output DATA_IN, WRITE, almost_Full, Full,
        input  DATA_OUT, push, ready, pausa
    );
endinterface

// File: rtl/qos_demux.sv
// QoS ingress demux: stages words in order and steers each to its class FIFO by the top 2 bits.
// Define QOS_DEMUX_DROPCNT_EN to build the per-class saturating drop counters.
module qos_demux #(
    parameter int DATA_WIDTH = 8,
    parameter int HOLD_DEPTH = 4,
    parameter int CNT_W      = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               init,
    qos_demux_if.slave         bus,
    output logic               err_drop,
    output logic [4*CNT_W-1:0] drop_count,
    output logic [1:0]         state
);
    localparam int                  PTR_W    = $clog2(HOLD_DEPTH);
    localparam int                  CNT_BITS = PTR_W + 1;
    localparam logic [CNT_BITS-1:0] DEPTH_C  = CNT_BITS'(HOLD_DEPTH);
    localparam logic [CNT_BITS-1:0] PAUSE_C  = CNT_BITS'(HOLD_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [HOLD_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [3:0]            push_q, push_d;
    logic                  err_drop_q, err_drop_d;

    logic                  active, ready_c, pausa_c;
    logic                  wr_en, drop, pop, head_blocked;
    logic [DATA_WIDTH-1:0] head;
    logic [1:0]            head_cls;

    // Acceptance uses the pre-pop count, so a pop on the same edge never rescues a write.
    always_comb begin
        active       = (state_q == RUN) || (state_q == STALL);
        ready_c      = active && (count_q < DEPTH_C);
        pausa_c      = !active || (count_q >= PAUSE_C);
        head         = mem_q[rd_ptr_q];
        head_cls     = head[DATA_WIDTH-1 -: 2];
        head_blocked = bus.almost_Full[head_cls] || bus.Full[head_cls];
        wr_en        = bus.WRITE && ready_c;
        drop         = bus.WRITE && active && !ready_c;
        pop          = (state_q == RUN) && init && (count_q != '0) && !head_blocked;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (!init)                                 state_d = IDLE;
                else if ((count_q != '0) && head_blocked)  state_d = STALL;
            end
            STALL: begin
                if (!init)              state_d = IDLE;
                else if (!head_blocked) state_d = RUN;
            end
            default: state_d = init ? RUN : IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
        data_out_d = pop ? head : data_out_q;
        push_d     = pop ? (4'b0001 << head_cls) : 4'b0000;
        err_drop_d = drop;
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            push_q     <= '0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            push_q     <= push_d;
            err_drop_q <= err_drop_d;
        end
    end

    // NOTE: staging storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_ptr_q] <= bus.DATA_IN;
    end

`ifdef QOS_DEMUX_DROPCNT_EN
    logic [3:0][CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [1:0]            in_cls;

    always_comb begin
        in_cls     = bus.DATA_IN[DATA_WIDTH-1 -: 2];
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q[in_cls] != '1))
            drop_cnt_d[in_cls] = drop_cnt_q[in_cls] + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

    assign bus.DATA_OUT = data_out_q;
    assign bus.push     = push_q;
    assign bus.ready    = ready_c;
    assign bus.pausa    = pausa_c;
    assign err_drop     = err_drop_q;
    assign state        = state_q;
endmodule

// File: tb/tb_qos_demux.sv
// Directed bench for qos_demux: a negedge monitor checks every push against a queue of expected words.
// Drop-counter expectations follow QOS_DEMUX_DROPCNT_EN.
module tb_qos_demux;
    localparam int DW = 8;
    localparam int HD = 4;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          init;
    logic          err_drop;
    logic [4*CW-1:0] drop_count;
    logic [1:0]    state;

    qos_demux_if #(.DATA_WIDTH(DW)) bus ();

    qos_demux #(.DATA_WIDTH(DW), .HOLD_DEPTH(HD), .CNT_W(CW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .init       (init),
        .bus        (bus),
        .err_drop   (err_drop),
        .drop_count (drop_count),
        .state      (state)
    );

    always #5 CLK = ~CLK;

    int          errors = 0;
    int          checks = 0;
    int          err_pulses = 0;
    bit          mon_en = 1'b0;
    logic [DW-1:0] exp_q [$];
    logic [CW-1:0] model_cnt [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drv(input logic [DW-1:0] d, input logic w);
        bus.DATA_IN = d;
        bus.WRITE   = w;
    endtask

    task automatic note_drop(input int cls);
        if (model_cnt[cls] != '1) model_cnt[cls] = model_cnt[cls] + 1'b1;
    endtask

    function automatic logic [31:0] exp_drops();
        logic [31:0] r;
        r = '0;
`ifdef QOS_DEMUX_DROPCNT_EN
        for (int i = 0; i < 4; i++) r[CW*i +: CW] = model_cnt[i];
`endif
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) model_cnt[i] = '0;
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: each push must match the oldest expected word and be one-hot for its class.
    always @(negedge CLK) begin
        if (mon_en) begin
            logic [DW-1:0] e;
            if (err_drop === 1'b1) err_pulses++;
            if (bus.push !== 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_push", bus.push, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", bus.DATA_OUT, e);
                    check("sb_onehot", bus.push, 32'(4'b0001 << e[DW-1 -: 2]));
                end
            end
        end
    end

    initial begin
        clear_model();
        RESET = 1'b1;
        init  = 1'b0;
        bus.almost_Full = 4'b0000;
        bus.Full        = 4'b0000;
        drv(8'hFF, 1'b1);

        // 1: reset with writes pending
        tick();
        mon_en = 1'b1;
        check("rst_push", bus.push, 0);
        check("rst_ready", bus.ready, 0);
        check("rst_pausa", bus.pausa, 1);
        check("rst_state", state, 0);
        check("rst_dout", bus.DATA_OUT, 0);
        check("rst_dropcnt", drop_count, 0);
        tick();
        check("rst_err", err_drop, 0);
        RESET = 1'b0;
        tick();
        tick();
        check("idle_state", state, 0);
        check("idle_ready", bus.ready, 0);
        check("idle_no_err", err_pulses, 0);
        check("idle_dropcnt", drop_count, 0);

        drv(8'h00, 1'b0);
        init = 1'b1;
        tick();
        check("run_state", state, 1);
        check("run_ready", bus.ready, 1);
        check("run_pausa", bus.pausa, 0);

        // 2: one word per class, back to back, 2-cycle latency
        drv(8'h05, 1'b1); exp_q.push_back(8'h05); tick();
        drv(8'h47, 1'b1); exp_q.push_back(8'h47); tick();
        check("lat_push0", bus.push, 4'b0001);
        check("lat_data0", bus.DATA_OUT, 8'h05);
        drv(8'h8A, 1'b1); exp_q.push_back(8'h8A); tick();
        check("lat_push1", bus.push, 4'b0010);
        check("lat_data1", bus.DATA_OUT, 8'h47);
        drv(8'hC3, 1'b1); exp_q.push_back(8'hC3); tick();
        check("lat_push2", bus.push, 4'b0100);
        drv(8'h00, 1'b0); tick();
        check("lat_push3", bus.push, 4'b1000);
        check("lat_data3", bus.DATA_OUT, 8'hC3);
        check("lat_state", state, 1);
        tick();
        check("lat_idle_push", bus.push, 0);

        // 3: blocked head holds a later word of an open class
        bus.almost_Full = 4'b0010;
        drv(8'h41, 1'b1); exp_q.push_back(8'h41); tick();
        drv(8'h02, 1'b1); exp_q.push_back(8'h02); tick();
        drv(8'h00, 1'b0);
        check("hol_state", state, 2);
        check("hol_push", bus.push, 0);
        tick();
        check("hol_state2", state, 2);
        check("hol_push2", bus.push, 0);
        bus.almost_Full = 4'b0000;
        tick();
        check("hol_resume", state, 1);
        check("hol_push3", bus.push, 0);
        tick();
        check("hol_first", bus.push, 4'b0010);
        check("hol_first_d", bus.DATA_OUT, 8'h41);
        tick();
        check("hol_second", bus.push, 4'b0001);
        check("hol_second_d", bus.DATA_OUT, 8'h02);
        drain("drain_hol", 10);

        // 4: fill staging behind a blocked class, overflow drops
        bus.almost_Full = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            drv(8'hC0 + 8'(i), 1'b1); exp_q.push_back(8'hC0 + 8'(i)); tick();
        end
        check("fill3_pausa", bus.pausa, 1);
        check("fill3_ready", bus.ready, 1);
        check("fill3_state", state, 2);
        drv(8'hC3, 1'b1); exp_q.push_back(8'hC3); tick();
        check("fill4_ready", bus.ready, 0);
        check("fill4_pausa", bus.pausa, 1);
        drv(8'hC4, 1'b1); note_drop(3); tick();
        check("drop4_err", err_drop, 1);
        drv(8'hC5, 1'b1); note_drop(3); tick();
        check("drop5_err", err_drop, 1);
        drv(8'h00, 1'b0); tick();
        check("drop_err_clr", err_drop, 0);
        check("drop_cnt_c3", drop_count, exp_drops());
        check("full_push", bus.push, 0);

        // 5: full staging, head popped on the same edge as a write: write still dropped
        bus.almost_Full = 4'b0000;
        tick();
        check("full_run", state, 1);
        check("full_ready", bus.ready, 0);
        drv(8'h80, 1'b1); note_drop(2); tick();
        drv(8'h00, 1'b0);
        check("popdrop_push", bus.push, 4'b0001 << 3);
        check("popdrop_data", bus.DATA_OUT, 8'hC0);
        check("popdrop_err", err_drop, 1);
        check("popdrop_ready", bus.ready, 1);
        drain("drain_full", 20);
        check("err_pulses_3", err_pulses, 3);
        check("drop_cnt_c2", drop_count, exp_drops());

        // 6: saturating drop count, then reset mid-transfer
        bus.almost_Full = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            drv(8'(i), 1'b1); exp_q.push_back(8'(i)); tick();
        end
        for (int i = 0; i < 20; i++) begin
            drv(8'h40 + 8'(i), 1'b1); note_drop(1); tick();
        end
        drv(8'h00, 1'b0); tick();
        check("sat_cnt", drop_count, exp_drops());
        check("err_pulses_23", err_pulses, 23);
        bus.almost_Full = 4'b0000;
        tick();
        tick();
        tick();
        check("mid_push", bus.push, 4'b0001);
        check("mid_data", bus.DATA_OUT, 8'h01);
        RESET = 1'b1;
        tick();
        exp_q.delete();
        clear_model();
        check("mid_rst_push", bus.push, 0);
        check("mid_rst_cnt", drop_count, 0);
        check("mid_rst_state", state, 0);
        check("mid_rst_dout", bus.DATA_OUT, 0);
        check("mid_rst_pausa", bus.pausa, 1);
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("post_rst_state", state, 1);
        check("post_rst_ready", bus.ready, 1);
        check("post_rst_pausa", bus.pausa, 0);
        check("post_rst_push", bus.push, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
